mul_div_unit: RTL

- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two source operands read from the register file, computes one of the eight RV32M operations over multiple cycles, and returns a 32-bit result.
- The result is returned with its destination register address, ready for the register-file write port.
- A start/busy/done handshake lets the core's control logic stall while an operation is in flight.

---
 rtl/rv32m_pkg.sv | 24 ++
 rtl/mdu_divider.sv | 58 +++++
 rtl/mul_div_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// rv32m_pkg: definitions shared by the RV32M multiply/divide unit.
//   - OP_* localparams: RV32M funct3 encodings.
//   - state_t: sequencing states (IDLE, RUN, DONE).
//   - XLEN_DEFAULT: default operand/result width.
package rv32m_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned restoring-divide datapath, one quotient bit per step.
// Sequencing comes from the parent; this block only holds the registers.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load         capture dividend/divisor magnitudes, clear remainder
//   step         perform one restoring iteration
//   dividend     unsigned dividend
//   divisor      unsigned divisor
//   quotient     quotient after XLEN steps
//   remainder    remainder after XLEN steps
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Remainder stays below the divisor, so the shifted partial remainder is
    // below 2*divisor and the top bit of diff is a clean borrow flag.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dsr_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit (XLEN+1 cycle latency).
// Optional feature macro: RV32M_DIV_EN (defined: divide ops built;
// undefined: ops 1xx finish with Result 0 and Illegal_Op 1).
// Ports:
//   CLK, Reset_n   clock, synchronous active-low reset
//   Start          request, sampled only in IDLE
//   Op             RV32M funct3
//   Operand_A/B    rs1 / rs2 contents
//   Add_Dest_In    rd for this operation
//   Busy           high from the cycle after accept through the Done cycle
//   Done           one-cycle completion pulse
//   Result         result, held until the next completion
//   Add_Dest_Out   rd captured at accept
//   Write_En_Out   Done qualified by rd != 0 and a legal op
//   Illegal_Op     pulses with Done for a compiled-out op
//   Fsm_State      current sequencing state (debug)
module mul_div_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] Operand_A,
    input  logic [XLEN-1:0] Operand_B,
    input  logic [4:0]      Add_Dest_In,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic [4:0]      Add_Dest_Out,
    output logic            Write_En_Out,
    output logic            Illegal_Op,
    output state_t          Fsm_State
);

    localparam int CW = $clog2(XLEN) + 1;

    // Handshake: Start is only looked at in IDLE; an accepted request raises
    // Busy on the next cycle and Busy stays high through the single Done
    // cycle. Requests during RUN/DONE are dropped, not queued.
    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic          accept, step, finish;

    always_ff @(posedge CLK) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (Start) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (count == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Fsm_State = state;

    always_ff @(posedge CLK) begin
        if (!Reset_n)    count <= '0;
        else if (accept) count <= CW'(XLEN);
        else if (step)   count <= count - CW'(1);
    end

    // Operand conditioning: magnitudes plus the sign the result must carry.
    logic            a_neg, b_neg, res_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        a_neg   = Operand_A[XLEN-1] &
                  ((Op == OP_MULH) | (Op == OP_MULHSU) | (Op == OP_DIV) | (Op == OP_REM));
        b_neg   = Operand_B[XLEN-1] & ((Op == OP_MULH) | (Op == OP_DIV) | (Op == OP_REM));
        res_neg = (Op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        mag_a   = a_neg ? -Operand_A : Operand_A;
        mag_b   = b_neg ? -Operand_B : Operand_B;
    end

    // Shift-add multiplier: low half starts as the multiplier and drains out
    // as the product's low word shifts in.
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN:0]     mul_sum;

    assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            op_q    <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else if (accept) begin
            op_q    <= Op;
            neg_q   <= res_neg;
            mcand_q <= mag_a;
            prod_q  <= {{XLEN{1'b0}}, mag_b};
        end else if (step) begin
            prod_q  <= {mul_sum, prod_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   mul_result, div_result;
    logic              op_legal;

    assign prod_signed = neg_q ? -prod_q : prod_q;
    assign mul_result  = (op_q == OP_MUL) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];

`ifdef RV32M_DIV_EN
    logic [XLEN-1:0] quo, rem;
    logic            special_q;
    logic [XLEN-1:0] special_val_q;

    mdu_divider #(.XLEN(XLEN)) u_divider (
        .clk       (CLK),
        .rst_n     (Reset_n),
        .load      (accept),
        .step      (step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem)
    );

    // Divide-by-zero and signed overflow are decided at capture; the divider
    // still runs so latency is unchanged.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            special_q     <= 1'b0;
            special_val_q <= '0;
        end else if (accept) begin
            if (Operand_B == '0) begin
                special_q     <= 1'b1;
                special_val_q <= Op[1] ? Operand_A : '1;
            end else if (!Op[0] && (Operand_A == {1'b1, {(XLEN-1){1'b0}}}) && (Operand_B == '1)) begin
                special_q     <= 1'b1;
                special_val_q <= Op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
                special_q     <= 1'b0;
                special_val_q <= '0;
            end
        end
    end

    always_comb begin
        if (special_q)  div_result = special_val_q;
        else if (op_q[1]) div_result = neg_q ? -rem : rem;
        else            div_result = neg_q ? -quo : quo;
    end

    assign op_legal = 1'b1;
`else
    assign div_result = '0;
    assign op_legal   = ~op_q[2];
`endif

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Result       <= '0;
            Add_Dest_Out <= '0;
            Write_En_Out <= 1'b0;
            Illegal_Op   <= 1'b0;
        end else begin
            Done         <= finish;
            Write_En_Out <= finish & op_legal & (Add_Dest_Out != 5'd0);
            Illegal_Op   <= finish & ~op_legal;
            if (accept) begin
                Busy         <= 1'b1;
                Add_Dest_Out <= Add_Dest_In;
            end else if (state == IDLE) begin
                Busy <= 1'b0;
            end
            if (finish) Result <= op_q[2] ? div_result : mul_result;
        end
    end

endmodule
